// File: rtl/mix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mix_pkg
//  Description : Shared types and per-lane coefficients for the mixing core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mix_pkg;

  // Core control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mix_state_t;

  // Odd per-lane multiplier (odd keeps each lane map invertible mod 2^WIDTH)
  function automatic int mix_mul(input int i);
    return 2 * i + 3;
  endfunction

  // Per-lane additive constant
  function automatic int mix_add(input int i);
    return i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_round.sv
`default_nettype none
// ============================================================================
//  Module      : mix_round
//  Description : One combinational mixing round: in-order chained add/sub
//                across the lanes followed by a per-lane multiply-add.
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_round
  import mix_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 8
) (
  input  logic [LANES*WIDTH-1:0] vec_in,
  output logic [LANES*WIDTH-1:0] vec_out
);

  // Chain updates lanes in place, so lane i sees already-updated lanes below
  // it, while lanes 0 and 1 still see the pre-round values of the top lanes.
  function automatic logic [LANES*WIDTH-1:0] apply_round(
    input logic [LANES*WIDTH-1:0] v_in
  );
    logic [LANES*WIDTH-1:0] v;
    logic [WIDTH-1:0]       cur;
    logic [WIDTH-1:0]       prev1;
    logic [WIDTH-1:0]       prev2;
    v = v_in;
    for (int i = 0; i < LANES; i++) begin
      cur   = v[i*WIDTH +: WIDTH];
      prev1 = v[((i + LANES - 1) % LANES)*WIDTH +: WIDTH];
      prev2 = v[((i + LANES - 2) % LANES)*WIDTH +: WIDTH];
      v[i*WIDTH +: WIDTH] = cur + prev1 - prev2;
    end
    for (int i = 0; i < LANES; i++) begin
      v[i*WIDTH +: WIDTH] = v[i*WIDTH +: WIDTH] * WIDTH'(mix_mul(i))
                          + WIDTH'(mix_add(i));
    end
    return v;
  endfunction

  // Single-cycle round, no pipelining
  assign vec_out = apply_round(vec_in);

endmodule
`default_nettype wire

// File: rtl/complex_mix_core.sv
`default_nettype none
// ============================================================================
//  Module      : complex_mix_core
//  Description : Handshaked multi-round mixing engine. Loads a lane vector,
//                applies ROUNDS mixing rounds (one per clock) and presents the
//                result until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module complex_mix_core
  import mix_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 8,
  parameter int ROUNDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       in_data,
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [$clog2(ROUNDS+1)-1:0]  round_idx
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_IDX = RW'(ROUNDS - 1);

  mix_state_t             state_q, state_d;
  logic [LANES*WIDTH-1:0] lanes_q, lanes_d;
  logic [RW-1:0]          round_idx_q, round_idx_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] round_out;

  mix_round #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_round (
    .vec_in  (lanes_q),
    .vec_out (round_out)
  );

  // Next-state, lane and counter updates; handshake flags follow next state
  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    round_idx_d = round_idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lanes_d     = in_data;
          round_idx_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        lanes_d     = round_out;
        round_idx_d = round_idx_q + RW'(1);
        if (round_idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          round_idx_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        round_idx_d = '0;
      end
    endcase
    // Cancel wins over everything except in IDLE, where it is a no-op
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      round_idx_d = '0;
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, lane and handshake registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lanes_q     <= '0;
      round_idx_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      round_idx_q <= round_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = lanes_q;
  assign round_idx = round_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_mix_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_complex_mix_core
//  Description : Self-checking bench: golden vectors on small configurations,
//                randomized blocks, backpressure, abort and async reset on the
//                default configuration, all against a lane-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_complex_mix_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: WIDTH=8, LANES=4, ROUNDS=1
  logic        a_in_valid, a_in_ready, a_abort, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [0:0]  a_round_idx;
  // Instance B: WIDTH=8, LANES=4, ROUNDS=2
  logic        b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_round_idx;
  // Instance C: defaults WIDTH=32, LANES=8, ROUNDS=4
  logic         c_in_valid, c_in_ready, c_abort, c_out_valid, c_out_ready;
  logic [255:0] c_in_data, c_out_data;
  logic [2:0]   c_round_idx;

  int n_checks = 0;
  int n_pass   = 0;

  complex_mix_core #(.WIDTH(8), .LANES(4), .ROUNDS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .abort(a_abort), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .round_idx(a_round_idx)
  );
  complex_mix_core #(.WIDTH(8), .LANES(4), .ROUNDS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .abort(b_abort), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .round_idx(b_round_idx)
  );
  complex_mix_core dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .abort(c_abort), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .round_idx(c_round_idx)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: lanes as an array of integers, rules applied literally
  function automatic logic [255:0] mix_model(input logic [255:0] v, input int w,
                                             input int l, input int r);
    longint unsigned x[8];
    longint unsigned mask;
    logic [255:0]    res;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < l; i++) x[i] = 64'(v >> (i * w)) & mask;
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < l; i++)
        x[i] = (x[i] + x[(i + l - 1) % l] - x[(i + l - 2) % l]) & mask;
      for (int i = 0; i < l; i++)
        x[i] = (x[i] * longint'(2 * i + 3) + longint'(i)) & mask;
    end
    res = '0;
    for (int i = 0; i < l; i++) res = res | (256'(x[i]) << (i * w));
    return res;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full block on instance C: accept, wait result, hold, release
  task automatic c_block(input logic [255:0] v, input int hold, input logic ab);
    int           cnt;
    logic         stable;
    logic [255:0] snap;
    check("c_pre_in_ready", c_in_ready, 1);
    c_in_valid = 1'b1;
    c_abort    = ab;
    c_in_data  = v;
    @(negedge clk);
    c_in_valid = 1'b0;
    c_abort    = 1'b0;
    c_in_data  = rand_vec();
    check("c_accept_in_ready", c_in_ready, 0);
    cnt = 0;
    while (c_out_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("c_latency", cnt, 4);
    check("c_data", c_out_data, mix_model(v, 32, 8, 4));
    check("c_round_idx_done", c_round_idx, 4);
    snap   = c_out_data;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (c_out_valid !== 1'b1 || c_out_data !== snap || c_in_ready !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) check("c_hold_stable", stable, 1);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    check("c_release_in_ready", c_in_ready, 1);
    check("c_release_out_valid", c_out_valid, 0);
    check("c_release_round_idx", c_round_idx, 0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    a_in_valid = 0; a_abort = 0; a_out_ready = 0; a_in_data = '0;
    b_in_valid = 0; b_abort = 0; b_out_ready = 0; b_in_data = '0;
    c_in_valid = 0; c_abort = 0; c_out_ready = 0; c_in_data = '0;
    #12;
    check("rst_in_ready", c_in_ready, 1);
    check("rst_out_valid", c_out_valid, 0);
    check("rst_round_idx", c_round_idx, 0);
    check("rst_out_data", c_out_data, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Golden: one round of all-zero lanes
    a_in_valid = 1'b1; a_in_data = 32'h0;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("a0_run_out_valid", a_out_valid, 0);
    check("a0_run_in_ready", a_in_ready, 0);
    @(negedge clk);
    check("a0_out_valid", a_out_valid, 1);
    check("a0_out_data", a_out_data, 32'h03020100);
    check("a0_model", mix_model(256'h0, 8, 4, 1), 32'h03020100);
    check("a0_round_idx", a_round_idx, 1);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("a0_release_in_ready", a_in_ready, 1);

    // Golden: lanes [1,0,0,0], exercises chain order and wrap
    a_in_valid = 1'b1; a_in_data = 32'h00000001;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("a1_out_valid", a_out_valid, 1);
    check("a1_out_data", a_out_data, 32'hFA020603);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;

    // Golden: two rounds of zeros, round_idx progression
    b_in_valid = 1'b1; b_in_data = 32'h0;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("b_round_idx0", b_round_idx, 0);
    @(negedge clk);
    check("b_round_idx1", b_round_idx, 1);
    check("b_mid_out_valid", b_out_valid, 0);
    @(negedge clk);
    check("b_round_idx2", b_round_idx, 2);
    check("b_out_valid", b_out_valid, 1);
    check("b_out_data", b_out_data, 32'h2702FC03);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;

    // Randomized blocks, first one with 5 cycles of backpressure
    for (int t = 0; t < 12; t++)
      c_block(rand_vec(), (t == 0) ? 5 : int'($urandom_range(0, 4)), 1'b0);

    // Abort in the second RUN cycle
    c_in_valid = 1'b1; c_in_data = rand_vec();
    @(negedge clk);
    c_in_valid = 1'b0;
    @(negedge clk);
    check("abort_pre_round_idx", c_round_idx, 1);
    c_abort = 1'b1;
    @(negedge clk);
    c_abort = 1'b0;
    check("abort_in_ready", c_in_ready, 1);
    check("abort_out_valid", c_out_valid, 0);
    check("abort_round_idx", c_round_idx, 0);
    seen = 1'b0;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      if (c_out_valid !== 1'b0) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    c_block(256'h0, 1, 1'b0);

    // Abort while IDLE is ignored and a simultaneous vector is accepted
    c_block(rand_vec(), 0, 1'b1);

    // Asynchronous reset mid-RUN
    c_in_valid = 1'b1; c_in_data = rand_vec();
    @(negedge clk);
    c_in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", c_out_valid, 0);
    check("arst_in_ready", c_in_ready, 1);
    check("arst_round_idx", c_round_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    c_block(rand_vec(), 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
